// File: rtl/keypad_event_controller_if.sv
// Key event handshake between the keypad controller and its consumer.
// master drives key_valid/key_code; slave returns key_ready.
interface keypad_event_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_event_controller.sv
// Keypad event sequencer: debounces scanner strobes, detects release, buffers presses in a FIFO.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat pushes while a key stays held.
//
// state    | meaning
// IDLE     | waiting for a scanner strobe
// DEBOUNCE | candidate code latched, counting held cycles
// PRESSED  | press accepted, key still down
// RELEASE  | key up, counting not-held cycles before accepting release
module keypad_event_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RELEASE_CYCLES  = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          scan_valid,
    input  logic [3:0]                    scan_code,
    input  logic                          key_held,
    keypad_event_controller_if.master     key_bus,
    output logic                          key_down,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int AW1     = AW + 1;
    localparam int TMR_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0]  DB_LOAD = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  RL_LOAD = TW'(RELEASE_CYCLES - 1);
    localparam logic [AW1-1:0] DEPTH_V = AW1'(FIFO_DEPTH);

    if (DEBOUNCE_CYCLES < 1 || RELEASE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("keypad_event_controller: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          push_press, push_rep;

    // One down-counter serves both debounce and release; the states never overlap.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        tmr_d      = tmr_q;
        push_press = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_valid) begin
                    cand_d  = scan_code;
                    tmr_d   = DB_LOAD;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!key_held) begin
                    state_d = S_IDLE;
                end else if (scan_valid && scan_code != cand_q) begin
                    cand_d = scan_code;
                    tmr_d  = DB_LOAD;
                end else if (tmr_q == '0) begin
                    push_press = 1'b1;
                    state_d    = S_PRESSED;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_PRESSED: begin
                if (!key_held) begin
                    tmr_d   = RL_LOAD;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (key_held) begin
                    state_d = S_PRESSED;
                end else if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW     = $clog2(RP_MAX + 1);
    localparam logic [RW-1:0] RP_DELAY_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_RATE_LOAD  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rep_q, rep_d;

    // Holds its value through RELEASE so a bounced release resumes the repeat timing.
    always_comb begin
        rep_d    = rep_q;
        push_rep = 1'b0;
        if (push_press) begin
            rep_d = RP_DELAY_LOAD;
        end else if (state_q == S_PRESSED && key_held) begin
            if (rep_q == '0) begin
                push_rep = 1'b1;
                rep_d    = RP_RATE_LOAD;
            end else begin
                rep_d = rep_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`else
    assign push_rep = 1'b0;
`endif

    logic [3:0]     mem [FIFO_DEPTH];
    logic [AW1-1:0] wr_q, rd_q, wr_d, rd_d;
    logic [3:0]     head_q, head_d;
    logic           valid, push_req, push_ok, pop, full, drop;

    assign valid      = (wr_q != rd_q);
    assign fifo_count = wr_q - rd_q;
    assign full       = (fifo_count == DEPTH_V);
    assign pop        = valid & key_bus.key_ready;
    assign push_req   = push_press | push_rep;
    assign push_ok    = push_req & (~full | pop);
    assign drop       = push_req & full & ~pop;
    assign wr_d       = wr_q + {{AW{1'b0}}, push_ok};
    assign rd_d       = rd_q + {{AW{1'b0}}, pop};

    // Next head bypasses the memory when it is the entry being written this cycle.
    always_comb begin
        head_d = 4'h0;
        if (wr_d != rd_d) begin
            if (push_ok && rd_d == wr_q) head_d = cand_q;
            else                         head_d = mem[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_q[AW-1:0]] <= cand_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cand_q   <= 4'h0;
            tmr_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            head_q   <= 4'h0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            tmr_q   <= tmr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            head_q  <= head_d;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    assign key_down          = (state_q == S_PRESSED) || (state_q == S_RELEASE);
    assign key_bus.key_valid = valid;
    assign key_bus.key_code  = head_q;
endmodule
